id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register with operand forwarding.
//
// Holds one decoded instruction. Source operands are forwarded combinationally
// from the MEM and WB stages (MEM has priority, x0 is never forwarded). A
// load in MEM that feeds a held source raises load_use_stall and withholds
// out_valid until the loaded value arrives through WB.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_*                upstream entry with valid/ready handshake
//   fwd_mem_*, fwd_wb_* forwarding sources from the MEM and WB stages
//   flush               discard the held entry and any incoming entry
//   out_valid/out_ready downstream handshake
//   alu_a, alu_b        selected ALU operands (pc/rs1, imm/rs2)
//   alu_op              ALU operation, reads 0 while no entry is held
//   out_store_data      forwarded rs2 value
//   out_rd, out_reg_write, out_is_load, out_pc  entry fields
//   load_use_stall      held entry waits on a load still in MEM
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_op,
    input  logic        in_use_pc,
    input  logic        in_use_imm,
    input  logic        in_is_load,
    input  logic        in_reg_write,
    input  logic        fwd_mem_valid,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        fwd_mem_is_load,
    input  logic        fwd_wb_valid,
    input  logic [4:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_is_load,
    output logic [31:0] out_store_data,
    output logic [31:0] out_pc,
    output logic        load_use_stall
);

    logic        valid_q,     valid_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] rs1_val_q,   rs1_val_d;
    logic [31:0] rs2_val_q,   rs2_val_d;
    logic [4:0]  rs1_q,       rs1_d;
    logic [4:0]  rs2_q,       rs2_d;
    logic [4:0]  rd_q,        rd_d;
    logic [31:0] imm_q,       imm_d;
    logic [3:0]  alu_op_q,    alu_op_d;
    logic        use_pc_q,    use_pc_d;
    logic        use_imm_q,   use_imm_d;
    logic        is_load_q,   is_load_d;
    logic        reg_write_q, reg_write_d;

    logic        mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic [31:0] keep_rs1, keep_rs2;
    logic        retire, accept;

    always_comb begin
        mem_hit1 = fwd_mem_valid && (fwd_mem_rd == rs1_q) && (rs1_q != 5'd0);
        mem_hit2 = fwd_mem_valid && (fwd_mem_rd == rs2_q) && (rs2_q != 5'd0);
        wb_hit1  = fwd_wb_valid  && (fwd_wb_rd  == rs1_q) && (rs1_q != 5'd0);
        wb_hit2  = fwd_wb_valid  && (fwd_wb_rd  == rs2_q) && (rs2_q != 5'd0);

        fwd_rs1 = mem_hit1 ? fwd_mem_data : (wb_hit1 ? fwd_wb_data : rs1_val_q);
        fwd_rs2 = mem_hit2 ? fwd_mem_data : (wb_hit2 ? fwd_wb_data : rs2_val_q);

        // Values captured while waiting: a load in MEM has no data yet, so
        // only non-load MEM results and WB results are absorbed into the entry.
        keep_rs1 = (mem_hit1 && !fwd_mem_is_load) ? fwd_mem_data
                 : (wb_hit1 ? fwd_wb_data : rs1_val_q);
        keep_rs2 = (mem_hit2 && !fwd_mem_is_load) ? fwd_mem_data
                 : (wb_hit2 ? fwd_wb_data : rs2_val_q);

        load_use_stall = valid_q && fwd_mem_valid && fwd_mem_is_load
                      && (fwd_mem_rd != 5'd0)
                      && (((fwd_mem_rd == rs1_q) && !use_pc_q) || (fwd_mem_rd == rs2_q));

        // rst also gates out_valid so nothing is handed downstream during reset.
        out_valid = valid_q && !load_use_stall && !flush && !rst;
        retire    = out_valid && out_ready;
        in_ready  = !rst && (!valid_q || retire);
        accept    = in_valid && in_ready && !flush;

        alu_a          = use_pc_q  ? pc_q  : fwd_rs1;
        alu_b          = use_imm_q ? imm_q : fwd_rs2;
        out_store_data = fwd_rs2;
        alu_op         = valid_q ? alu_op_q : 4'd0;
        out_pc         = pc_q;
        out_rd         = rd_q;
        out_reg_write  = reg_write_q;
        out_is_load    = is_load_q;
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        use_pc_d    = use_pc_q;
        use_imm_d   = use_imm_q;
        is_load_d   = is_load_q;
        reg_write_d = reg_write_q;

        if (rst) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_val_d   = '0;
            rs2_val_d   = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            imm_d       = '0;
            alu_op_d    = '0;
            use_pc_d    = 1'b0;
            use_imm_d   = 1'b0;
            is_load_d   = 1'b0;
            reg_write_d = 1'b0;
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            pc_d        = in_pc;
            rs1_val_d   = in_rs1_val;
            rs2_val_d   = in_rs2_val;
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            imm_d       = in_imm;
            alu_op_d    = in_alu_op;
            use_pc_d    = in_use_pc;
            use_imm_d   = in_use_imm;
            is_load_d   = in_is_load;
            reg_write_d = in_reg_write;
        end else if (retire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            rs1_val_d = keep_rs1;
            rs2_val_d = keep_rs2;
        end
    end

    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        pc_q        <= pc_d;
        rs1_val_q   <= rs1_val_d;
        rs2_val_q   <= rs2_val_d;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        rd_q        <= rd_d;
        imm_q       <= imm_d;
        alu_op_q    <= alu_op_d;
        use_pc_q    <= use_pc_d;
        use_imm_q   <= use_imm_d;
        is_load_q   <= is_load_d;
        reg_write_q <= reg_write_d;
    end

endmodule
